// File: rtl/hazard_scoreboard_if.sv
// Decode-to-hazard-unit bundle: decoded register-write controls in,
// stall / bypass selects / mult-div scoreboard out.
interface hazard_scoreboard_if #(
   parameter int REG_BITS = 5
);
   logic                id_valid;
   logic [REG_BITS-1:0] id_rs_a;
   logic [REG_BITS-1:0] id_rs_b;
   logic                id_we;
   logic [REG_BITS-1:0] id_wreg;
   logic                id_is_load;
   logic                id_is_multdiv;
   logic                md_done;
   logic                stall;
   logic [1:0]          fwd_a;
   logic [1:0]          fwd_b;
   logic                md_busy;
   logic [REG_BITS-1:0] md_wreg;

   modport master (
      output id_valid, id_rs_a, id_rs_b, id_we, id_wreg, id_is_load, id_is_multdiv, md_done,
      input  stall, fwd_a, fwd_b, md_busy, md_wreg
   );

   modport slave (
      input  id_valid, id_rs_a, id_rs_b, id_we, id_wreg, id_is_load, id_is_multdiv, md_done,
      output stall, fwd_a, fwd_b, md_busy, md_wreg
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks decoded register writes through X/M/W to generate the decode stall,
// registered execute bypass selects and the single outstanding mult/div destination.
module hazard_scoreboard #(
   parameter int                  REG_BITS = 5,
   parameter logic [REG_BITS-1:0] ZERO_REG = '0
) (
   input  logic               clock,
   input  logic               reset,
   hazard_scoreboard_if.slave bus
);

   typedef struct packed {
      logic                valid;
      logic                we;
      logic [REG_BITS-1:0] wreg;
      logic                is_load;
      logic                is_multdiv;
   } stage_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_XM = 2'b01;
   localparam logic [1:0] FWD_MW = 2'b10;

   stage_t              x_q, x_d, m_q, m_d, w_q, w_d;
   logic                md_busy_q, md_busy_d;
   logic [REG_BITS-1:0] md_wreg_q, md_wreg_d;
   logic [1:0]          fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic                stall;
   logic                md_pending;

   function automatic logic is_writer(input stage_t s);
      return s.valid & s.we & (s.wreg != ZERO_REG) & ~s.is_multdiv;
   endfunction

   function automatic logic reads(input logic [REG_BITS-1:0] rs, input logic [REG_BITS-1:0] wreg);
      return (rs != ZERO_REG) && (rs == wreg);
   endfunction

   function automatic logic [1:0] fwd_sel(input stage_t x, input stage_t m,
                                          input logic [REG_BITS-1:0] rs);
      if (is_writer(x) && reads(rs, x.wreg))      return FWD_XM;
      else if (is_writer(m) && reads(rs, m.wreg)) return FWD_MW;
      else                                        return FWD_RF;
   endfunction

   // A result still owed by the mult/div unit; md_done releases it in the same cycle.
   assign md_pending = md_busy_q & ~bus.md_done;

   always_comb begin
      logic haz_load, haz_md, haz_md_x, haz_struct;
      haz_load   = is_writer(x_q) & x_q.is_load &
                   (reads(bus.id_rs_a, x_q.wreg) | reads(bus.id_rs_b, x_q.wreg));
      haz_md     = md_pending & (md_wreg_q != ZERO_REG) &
                   ((md_wreg_q == bus.id_rs_a) | (md_wreg_q == bus.id_rs_b) |
                    (bus.id_we & (md_wreg_q == bus.id_wreg)));
      haz_md_x   = x_q.valid & x_q.is_multdiv & (x_q.wreg != ZERO_REG) &
                   ((x_q.wreg == bus.id_rs_a) | (x_q.wreg == bus.id_rs_b) |
                    (x_q.wreg == bus.id_wreg));
      haz_struct = bus.id_is_multdiv & (md_pending | (x_q.valid & x_q.is_multdiv));
      stall      = bus.id_valid & (haz_load | haz_md | haz_md_x | haz_struct);
   end

   always_comb begin
      w_d = m_q;
      m_d = x_q;
      x_d = '{valid: bus.id_valid & ~stall, we: bus.id_we, wreg: bus.id_wreg,
              is_load: bus.id_is_load, is_multdiv: bus.id_is_multdiv};

      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (bus.id_valid && !stall) begin
         fwd_a_d = fwd_sel(x_q, m_q, bus.id_rs_a);
         fwd_b_d = fwd_sel(x_q, m_q, bus.id_rs_b);
      end

      // A new mult/div leaving X takes priority over a completion on the same edge.
      md_busy_d = md_busy_q;
      md_wreg_d = md_wreg_q;
      if (x_q.valid && x_q.is_multdiv) begin
         md_busy_d = 1'b1;
         md_wreg_d = x_q.wreg;
      end else if (bus.md_done && md_busy_q) begin
         md_busy_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q.valid <= 1'b0;
         m_q.valid <= 1'b0;
         w_q.valid <= 1'b0;
         md_busy_q <= 1'b0;
         md_wreg_q <= '0;
         fwd_a_q   <= FWD_RF;
         fwd_b_q   <= FWD_RF;
      end else begin
         x_q       <= x_d;
         m_q       <= m_d;
         w_q       <= w_d;
         md_busy_q <= md_busy_d;
         md_wreg_q <= md_wreg_d;
         fwd_a_q   <= fwd_a_d;
         fwd_b_q   <= fwd_b_d;
      end
   end

   assign bus.stall   = stall;
   assign bus.fwd_a   = fwd_a_q;
   assign bus.fwd_b   = fwd_b_q;
   assign bus.md_busy = md_busy_q;
   assign bus.md_wreg = md_wreg_q;

   // W is kept for pipeline depth/debug visibility; nothing downstream reads it here.
   logic unused_w;
   assign unused_w = ^w_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding distances, load-use,
// mult/div scoreboard, zero-register and reset flush scenarios.
module tb_hazard_scoreboard;

   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   hazard_scoreboard_if #(.REG_BITS(5)) bus ();

   hazard_scoreboard #(.REG_BITS(5), .ZERO_REG(5'd0)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                         input logic we, input logic [4:0] wr, input logic ld, input logic md);
      bus.id_valid      = v;
      bus.id_rs_a       = ra;
      bus.id_rs_b       = rb;
      bus.id_we         = we;
      bus.id_wreg       = wr;
      bus.id_is_load    = ld;
      bus.id_is_multdiv = md;
      #1;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic flush();
      nop();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.md_done = 1'b0;
      nop();
      repeat (2) tick();
      n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_md_busy: got %0b expected 0", bus.md_busy); end
      n_checks++; if (bus.md_wreg !== 5'd0) begin n_fail++; $display("FAIL rst_md_wreg: got %0d expected 0", bus.md_wreg); end
      n_checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL rst_fwd: got %b/%b expected 00/00", bus.fwd_a, bus.fwd_b); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b expected 0", bus.stall); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_forward_distance();
      // back-to-back: add r3 ; add r4,r3,r3
      flush();
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 0, 0);
      tick();
      set_id(1, 5'd3, 5'd3, 1, 5'd4, 0, 0);
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fwd1_stall: got %0b expected 0", bus.stall); end
      tick();
      n_checks++; if (bus.fwd_a !== 2'b01 || bus.fwd_b !== 2'b01) begin n_fail++; $display("FAIL fwd1_sel: got %b/%b expected 01/01", bus.fwd_a, bus.fwd_b); end
      // one NOP between
      flush();
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 0, 0);
      tick();
      nop();
      tick();
      set_id(1, 5'd3, 5'd3, 1, 5'd4, 0, 0);
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fwd2_stall: got %0b expected 0", bus.stall); end
      tick();
      n_checks++; if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b10) begin n_fail++; $display("FAIL fwd2_sel: got %b/%b expected 10/10", bus.fwd_a, bus.fwd_b); end
      // two NOPs between
      flush();
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 0, 0);
      tick();
      nop();
      tick();
      tick();
      set_id(1, 5'd3, 5'd3, 1, 5'd4, 0, 0);
      tick();
      n_checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL fwd3_sel: got %b/%b expected 00/00", bus.fwd_a, bus.fwd_b); end
   endtask

   task automatic test_load_use();
      flush();
      set_id(1, 5'd1, 5'd1, 1, 5'd5, 1, 0);
      tick();
      set_id(1, 5'd5, 5'd1, 1, 5'd6, 0, 0);
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %0b expected 1", bus.stall); end
      tick();
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2: got %0b expected 0", bus.stall); end
      n_checks++; if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_fwd: got %b expected 00", bus.fwd_a); end
      tick();
      nop();
      n_checks++; if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd: got %b/%b expected 10/00", bus.fwd_a, bus.fwd_b); end
   endtask

   task automatic test_multdiv_raw();
      flush();
      set_id(1, 5'd1, 5'd2, 1, 5'd7, 0, 1);
      tick();
      set_id(1, 5'd7, 5'd2, 1, 5'd8, 0, 0);
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL md_x_stall: got %0b expected 1", bus.stall); end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (bus.stall !== 1'b1 || bus.md_busy !== 1'b1 || bus.md_wreg !== 5'd7) begin
            n_fail++; $display("FAIL md_wait%0d: got stall=%0b busy=%0b wreg=%0d expected 1/1/7", i, bus.stall, bus.md_busy, bus.md_wreg);
         end
         tick();
      end
      bus.md_done = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL md_done_stall: got %0b expected 0", bus.stall); end
      tick();
      bus.md_done = 1'b0;
      nop();
      n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL md_clear: got %0b expected 0", bus.md_busy); end
      n_checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL md_fwd: got %b/%b expected 00/00", bus.fwd_a, bus.fwd_b); end
   endtask

   task automatic test_multdiv_struct();
      flush();
      set_id(1, 5'd1, 5'd2, 1, 5'd7, 0, 1);
      tick();
      set_id(1, 5'd1, 5'd2, 1, 5'd9, 0, 1);
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL st_stall_x: got %0b expected 1", bus.stall); end
      tick();
      n_checks++; if (bus.stall !== 1'b1 || bus.md_busy !== 1'b1 || bus.md_wreg !== 5'd7) begin
         n_fail++; $display("FAIL st_busy: got stall=%0b busy=%0b wreg=%0d expected 1/1/7", bus.stall, bus.md_busy, bus.md_wreg);
      end
      tick();
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL st_stall_hold: got %0b expected 1", bus.stall); end
      bus.md_done = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL st_release: got %0b expected 0", bus.stall); end
      tick();
      bus.md_done = 1'b0;
      nop();
      tick();
      n_checks++; if (bus.md_busy !== 1'b1 || bus.md_wreg !== 5'd9) begin
         n_fail++; $display("FAIL st_div_issue: got busy=%0b wreg=%0d expected 1/9", bus.md_busy, bus.md_wreg);
      end
      bus.md_done = 1'b1;
      tick();
      bus.md_done = 1'b0;
      n_checks++; if (bus.md_busy !== 1'b0 || bus.md_wreg !== 5'd9) begin
         n_fail++; $display("FAIL st_div_done: got busy=%0b wreg=%0d expected 0/9", bus.md_busy, bus.md_wreg);
      end
      bus.md_done = 1'b1;
      tick();
      bus.md_done = 1'b0;
      n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL st_done_idle: got %0b expected 0", bus.md_busy); end
   endtask

   task automatic test_zero_reg();
      flush();
      set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 0);
      tick();
      set_id(1, 5'd0, 5'd0, 1, 5'd1, 0, 0);
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0b expected 0", bus.stall); end
      tick();
      n_checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL r0_fwd: got %b/%b expected 00/00", bus.fwd_a, bus.fwd_b); end
      flush();
      set_id(1, 5'd0, 5'd0, 1, 5'd30, 0, 0);
      tick();
      set_id(1, 5'd30, 5'd1, 1, 5'd2, 0, 0);
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL r30_stall: got %0b expected 0", bus.stall); end
      tick();
      n_checks++; if (bus.fwd_a !== 2'b01 || bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL r30_fwd: got %b/%b expected 01/00", bus.fwd_a, bus.fwd_b); end
   endtask

   task automatic test_reset_flush();
      flush();
      set_id(1, 5'd1, 5'd2, 1, 5'd7, 0, 1);
      tick();
      set_id(1, 5'd1, 5'd1, 1, 5'd5, 1, 0);
      tick();
      set_id(1, 5'd5, 5'd7, 1, 5'd6, 0, 0);
      n_checks++; if (bus.stall !== 1'b1 || bus.md_busy !== 1'b1) begin
         n_fail++; $display("FAIL rf_pre: got stall=%0b busy=%0b expected 1/1", bus.stall, bus.md_busy);
      end
      reset = 1'b1;
      tick();
      n_checks++; if (bus.md_busy !== 1'b0 || bus.md_wreg !== 5'd0) begin
         n_fail++; $display("FAIL rf_md: got busy=%0b wreg=%0d expected 0/0", bus.md_busy, bus.md_wreg);
      end
      n_checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL rf_fwd: got %b/%b expected 00/00", bus.fwd_a, bus.fwd_b); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rf_stall_a: got %0b expected 0", bus.stall); end
      set_id(1, 5'd7, 5'd5, 1, 5'd7, 0, 1);
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rf_stall_b: got %0b expected 0", bus.stall); end
      reset = 1'b0;
      nop();
      tick();
   endtask

   initial begin
      test_reset();
      test_forward_distance();
      test_load_use();
      test_multdiv_raw();
      test_multdiv_struct();
      test_zero_reg();
      test_reset_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
